fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req_out, output, 1: instruction memory request valid.
REQ-005 SHALL have port imem_addr_out, output, 32: request address, word aligned.
REQ-006 SHALL have port imem_ready_in, input, 1: memory accepts request this cycle when high with imem_req_out.
REQ-007 SHALL have port imem_rvalid_in, input, 1: read data valid.
REQ-008 SHALL have port imem_rdata_in, input, 32: instruction word.
REQ-009 SHALL have port instruction_reg_out, output, 32: registered instruction to decode stage.
REQ-010 SHALL have port program_counter_reg_out, output, 32: registered PC of instruction_reg_out.
REQ-011 SHALL have port status_forwards_out, output, pipeline_status::forwards_t: VALID or BUBBLE to decode stage.
REQ-012 SHALL have port status_backwards_in, input, pipeline_status::backwards_t: READY, STALL or JUMP from decode stage.
REQ-013 SHALL have port jump_address_backwards_in, input, 32: redirect target, valid when status_backwards_in == JUMP.
REQ-014 SHALL have port misaligned_out, output, 1: one-cycle pulse on misaligned redirect.

Function
REQ-015 SHALL implement FSM states IDLE, REQUEST, WAIT, KILL; one request outstanding at most.
REQ-016 IDLE SHALL go to REQUEST one cycle after reset release; IDLE issues no request.
REQ-017 REQUEST: imem_req_out=1, imem_addr_out=fetch PC; on imem_ready_in go to WAIT, else hold address and stay.
REQ-018 WAIT: on imem_rvalid_in capture imem_rdata_in and fetch PC; fetch PC += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); go to REQUEST.
REQ-019 Capture SHALL load instruction_reg_out/program_counter_reg_out and drive VALID next cycle when status_backwards_in != STALL.
REQ-020 Under STALL, output registers and status_forwards_out SHALL hold; a response arriving under STALL SHALL go to a one-entry hold register and FSM SHALL stay in WAIT (no new request) until STALL drops, then hold entry moves to output.
REQ-021 Cycles with no new instruction and no STALL SHALL drive BUBBLE.
REQ-022 JUMP SHALL: set fetch PC to jump_address_backwards_in, flush hold register, drive BUBBLE next cycle; from REQUEST (not yet accepted) retarget address same cycle; from WAIT go to KILL.
REQ-023 KILL SHALL discard the next imem_rvalid_in response, then go to REQUEST at the redirect PC; JUMP coinciding with rvalid in WAIT SHALL discard that response and go to REQUEST.
REQ-024 JUMP SHALL take priority over STALL and over a simultaneous response.
REQ-025 Fetch-to-VALID latency SHALL be 1 cycle after imem_rvalid_in with zero-wait memory: 1 instruction per 2 cycles minimum.

Reset
REQ-026 While rst low: state IDLE, fetch PC=RESET_PC, imem_req_out=0, imem_addr_out=RESET_PC, instruction_reg_out=32'h0000_0013 (NOP), program_counter_reg_out=0, status_forwards_out=BUBBLE, misaligned_out=0, hold register empty.
REQ-027 Reset asserted mid-transaction SHALL abandon the outstanding request; responses after reset release while in IDLE SHALL be ignored.

Configuration
REQ-028 Macro FETCH_MISALIGN_TRAP_EN: defined -> JUMP target with bits[1:0]!=0 pulses misaligned_out, drives BUBBLE, FSM goes to IDLE until next JUMP; undefined -> bits[1:0] forced to 0, misaligned_out tied 0.

Verification
REQ-029 Reset release, RESET_PC=0, zero-wait memory returning addr -> addresses 0,4,8; VALID with PC 0,4,8 every second cycle.
REQ-030 STALL held 3 cycles while response for PC 8 arrives -> outputs hold PC 4, no new request, PC 8 VALID first cycle after STALL drops.
REQ-031 JUMP to 32'h100 while WAIT on PC 12 -> PC 12 data discarded, next request 32'h100, BUBBLE until 32'h100 VALID.
REQ-032 JUMP and STALL same cycle with rvalid -> redirect taken, response dropped.
REQ-033 JUMP to 32'hFFFF_FFFC -> next request address 32'h0000_0000 after fetch.
REQ-034 JUMP to 32'h102 -> with FETCH_MISALIGN_TRAP_EN: misaligned_out pulse, no request; without: request 32'h100.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with stall hold buffer and redirect/kill.
// Optional macro FETCH_MISALIGN_TRAP_EN traps misaligned redirects instead of masking bits[1:0].
`default_nettype none

package pipeline_status;
    typedef enum logic {
        BUBBLE = 1'b0,
        VALID  = 1'b1
    } forwards_t;

    typedef enum logic [1:0] {
        READY = 2'd0,
        STALL = 2'd1,
        JUMP  = 2'd2
    } backwards_t;
endpackage

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req_out,
    output logic [31:0]                  imem_addr_out,
    input  logic                         imem_ready_in,
    input  logic                         imem_rvalid_in,
    input  logic [31:0]                  imem_rdata_in,
    output logic [31:0]                  instruction_reg_out,
    output logic [31:0]                  program_counter_reg_out,
    output pipeline_status::forwards_t   status_forwards_out,
    input  pipeline_status::backwards_t  status_backwards_in,
    input  logic [31:0]                  jump_address_backwards_in,
    output logic                         misaligned_out
);
    import pipeline_status::*;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2,
        KILL    = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_out;
    forwards_t   r_status;
    logic        r_hold_valid;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_misaligned;
    logic        r_trapped;

    logic        w_jump;
    logic        w_stall;
    logic        w_misaligned;
    logic [31:0] w_target;
    logic        w_accept;
    logic        w_resp;

    assign w_jump  = (status_backwards_in == JUMP);
    assign w_stall = (status_backwards_in == STALL);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_misaligned = w_jump && (jump_address_backwards_in[1:0] != 2'b00);
    assign w_target     = jump_address_backwards_in;
`else
    assign w_misaligned = 1'b0;
    assign w_target     = jump_address_backwards_in & 32'hFFFF_FFFC;
`endif

    // A redirect during an unaccepted request retargets the address combinationally.
    assign imem_req_out  = (r_state == REQUEST) && !w_misaligned;
    assign imem_addr_out = ((r_state == REQUEST) && w_jump) ? w_target : r_pc;
    assign w_accept      = imem_req_out && imem_ready_in;
    assign w_resp        = (r_state == WAIT) && !r_hold_valid && imem_rvalid_in;

    assign instruction_reg_out     = r_instr;
    assign program_counter_reg_out = r_pc_out;
    assign status_forwards_out     = r_status;
    assign misaligned_out          = r_misaligned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_instr      <= C_NOP;
            r_pc_out     <= 32'h0000_0000;
            r_status     <= BUBBLE;
            r_hold_valid <= 1'b0;
            r_hold_instr <= C_NOP;
            r_hold_pc    <= 32'h0000_0000;
            r_misaligned <= 1'b0;
            r_trapped    <= 1'b0;
        end else begin
            r_misaligned <= w_misaligned;
            if (w_jump) begin
                r_status     <= BUBBLE;
                r_hold_valid <= 1'b0;
                if (w_misaligned) begin
                    r_state   <= IDLE;
                    r_trapped <= 1'b1;
                end else begin
                    r_trapped <= 1'b0;
                    r_pc      <= w_target;
                    case (r_state)
                        REQUEST: r_state <= w_accept ? WAIT : REQUEST;
                        // With an entry already held nothing is in flight, so no kill is needed.
                        WAIT:    r_state <= (imem_rvalid_in || r_hold_valid) ? REQUEST : KILL;
                        KILL:    r_state <= imem_rvalid_in ? REQUEST : KILL;
                        default: r_state <= REQUEST;
                    endcase
                end
            end else begin
                case (r_state)
                    IDLE: begin
                        if (!r_trapped) r_state <= REQUEST;
                    end
                    REQUEST: begin
                        if (imem_ready_in) r_state <= WAIT;
                    end
                    WAIT: begin
                        if (w_resp) begin
                            r_pc <= r_pc + 32'd4;
                            if (w_stall) begin
                                r_hold_valid <= 1'b1;
                                r_hold_instr <= imem_rdata_in;
                                r_hold_pc    <= r_pc;
                            end else begin
                                r_state <= REQUEST;
                            end
                        end else if (r_hold_valid && !w_stall) begin
                            r_state <= REQUEST;
                        end
                    end
                    default: begin
                        if (imem_rvalid_in) r_state <= REQUEST;
                    end
                endcase

                if (!w_stall) begin
                    if (w_resp) begin
                        r_instr  <= imem_rdata_in;
                        r_pc_out <= r_pc;
                        r_status <= VALID;
                    end else if (r_hold_valid) begin
                        r_instr      <= r_hold_instr;
                        r_pc_out     <= r_hold_pc;
                        r_status     <= VALID;
                        r_hold_valid <= 1'b0;
                    end else begin
                        r_status <= BUBBLE;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
